cache: RTL

Direct-mapped, write-back, write-allocate cache between the multicycle RV32I `cpu` memory port and physical memory. It accepts single-word CPU requests (`mem_*`) and services them from a local line array, or fetches and evicts 256-bit lines over a `pmem_*` handshake. Hits complete in the request cycle; misses stall the CPU through `mem_resp` until the line is resident.

---
 rtl/cache_pkg.sv | 26 ++
 rtl/cache_if.sv | 34 +++
 rtl/cache_array.sv | 56 +++++
 rtl/cache.sv | 126 ++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types for the direct-mapped write-back cache: FSM states, line type, default geometry.
// The optional statistics counters are enabled with the CACHE_STATS_EN macro (see cache.sv).
package cache_types;

  localparam int DEF_S_INDEX  = 3;
  localparam int DEF_S_OFFSET = 5;

  typedef logic [255:0] cache_line_t;

  typedef enum logic [1:0] {
    CHECK,
    WRITEBACK,
    ALLOCATE
  } cache_state_t;

  // Merge one 32-bit word into a line, byte lane by byte lane.
  function automatic cache_line_t merge_word(cache_line_t line, logic [2:0] word,
                                             logic [3:0] be, logic [31:0] data);
    cache_line_t r;
    r = line;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[int'(word)*32 + b*8 +: 8] = data[b*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/cache_if.sv
// CPU-side and physical-memory-side bus of the cache; the cache is the slave modport,
// the CPU/memory environment is the master modport.
interface cache_if;
  import cache_types::*;

  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic        mem_resp;
  logic [31:0] mem_rdata;

  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  cache_line_t pmem_wdata;
  logic        pmem_resp;
  cache_line_t pmem_rdata;

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_resp, mem_rdata,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_resp, pmem_rdata
  );

  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_resp, mem_rdata,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_resp, pmem_rdata
  );
endinterface

// File: rtl/cache_array.sv
// Per-set line storage: asynchronous read, synchronous fill / byte-merged word write.
// Only valid and dirty bits are reset; data and tags keep whatever they held.
module cache_array
  import cache_types::*;
#(
  parameter int S_INDEX = DEF_S_INDEX,
  parameter int TAG_W   = 32 - DEF_S_INDEX - DEF_S_OFFSET
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [S_INDEX-1:0] index_i,
  output cache_line_t        data_o,
  output logic [TAG_W-1:0]   tag_o,
  output logic               valid_o,
  output logic               dirty_o,
  input  logic               fill_i,
  input  logic [TAG_W-1:0]   fill_tag_i,
  input  cache_line_t        fill_data_i,
  input  logic               wr_i,
  input  logic [2:0]         wr_word_i,
  input  logic [3:0]         wr_be_i,
  input  logic [31:0]        wr_data_i
);
  localparam int SETS = 1 << S_INDEX;

  cache_line_t        data_q [SETS];
  logic [TAG_W-1:0]   tag_q  [SETS];
  logic [SETS-1:0]    valid_q;
  logic [SETS-1:0]    dirty_q;

  assign data_o  = data_q[index_i];
  assign tag_o   = tag_q[index_i];
  assign valid_o = valid_q[index_i];
  assign dirty_o = dirty_q[index_i];

  always_ff @(posedge clk) begin
    if (fill_i) begin
      data_q[index_i] <= fill_data_i;
      tag_q[index_i]  <= fill_tag_i;
    end else if (wr_i) begin
      data_q[index_i] <= merge_word(data_q[index_i], wr_word_i, wr_be_i, wr_data_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_i) begin
      valid_q[index_i] <= 1'b1;
      dirty_q[index_i] <= 1'b0;
    end else if (wr_i) begin
      dirty_q[index_i] <= 1'b1;
    end
  end
endmodule

// File: rtl/cache.sv
// Direct-mapped write-back/write-allocate cache: hit compare, CHECK/WRITEBACK/ALLOCATE FSM,
// pmem address mux. Define CACHE_STATS_EN to add access/miss/writeback counters.
module cache
  import cache_types::*;
#(
  parameter int S_INDEX  = DEF_S_INDEX,
  parameter int S_OFFSET = DEF_S_OFFSET
) (
  input  logic        clk,
  input  logic        rst,
  cache_if.slave      bus
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0] access_count,
  output logic [31:0] miss_count,
  output logic [31:0] wb_count
`endif
);
  localparam int TAG_W = 32 - S_INDEX - S_OFFSET;

  cache_state_t       state_q, state_d;
  logic [S_INDEX-1:0] idx;
  logic [TAG_W-1:0]   req_tag;
  logic [2:0]         word;
  cache_line_t        line;
  logic [TAG_W-1:0]   line_tag;
  logic               line_valid, line_dirty;
  logic               req, hit, fill, wr, wb_done;
  logic               unused_addr;

  assign idx         = bus.mem_address[S_OFFSET +: S_INDEX];
  assign req_tag     = bus.mem_address[31 -: TAG_W];
  assign word        = bus.mem_address[S_OFFSET-1:2];
  assign unused_addr = ^bus.mem_address[1:0];
  assign req         = bus.mem_read | bus.mem_write;
  assign hit         = line_valid && (line_tag == req_tag);

  cache_array #(.S_INDEX(S_INDEX), .TAG_W(TAG_W)) u_array (
    .clk         (clk),
    .rst         (rst),
    .index_i     (idx),
    .data_o      (line),
    .tag_o       (line_tag),
    .valid_o     (line_valid),
    .dirty_o     (line_dirty),
    .fill_i      (fill),
    .fill_tag_i  (req_tag),
    .fill_data_i (bus.pmem_rdata),
    .wr_i        (wr),
    .wr_word_i   (word),
    .wr_be_i     (bus.mem_byte_enable),
    .wr_data_i   (bus.mem_wdata)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= CHECK;
    else     state_q <= state_d;
  end

  // Everything is gated by rst so an abandoned miss drops its pmem strobe in the reset cycle.
  always_comb begin
    state_d          = state_q;
    bus.mem_resp     = 1'b0;
    bus.mem_rdata    = '0;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = '0;
    bus.pmem_wdata   = '0;
    fill             = 1'b0;
    wr               = 1'b0;
    wb_done          = 1'b0;
    if (!rst) begin
      case (state_q)
        CHECK: begin
          if (req) begin
            if (hit) begin
              bus.mem_resp  = 1'b1;
              bus.mem_rdata = line[int'(word)*32 +: 32];
              wr            = bus.mem_write;
            end else begin
              state_d = (line_valid && line_dirty) ? WRITEBACK : ALLOCATE;
            end
          end
        end
        WRITEBACK: begin
          bus.pmem_write   = 1'b1;
          bus.pmem_address = {line_tag, idx, {S_OFFSET{1'b0}}};
          bus.pmem_wdata   = line;
          if (bus.pmem_resp) begin
            wb_done = 1'b1;
            state_d = ALLOCATE;
          end
        end
        ALLOCATE: begin
          bus.pmem_read    = 1'b1;
          bus.pmem_address = {req_tag, idx, {S_OFFSET{1'b0}}};
          if (bus.pmem_resp) begin
            fill    = 1'b1;
            state_d = CHECK;
          end
        end
        default: state_d = CHECK;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] access_q, miss_q, wb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      access_q <= '0;
      miss_q   <= '0;
      wb_q     <= '0;
    end else begin
      if (bus.mem_resp) access_q <= access_q + 32'd1;
      if (fill)         miss_q   <= miss_q + 32'd1;
      if (wb_done)      wb_q     <= wb_q + 32'd1;
    end
  end

  assign access_count = access_q;
  assign miss_count   = miss_q;
  assign wb_count     = wb_q;
`endif
endmodule
